// File: rtl/hsv_frame_scheduler.sv
// hsv_frame_scheduler: runs one LED-strip frame through the shared HSV-to-RGB
// converter and streams the indexed RGB results to the LED driver.
//
// Optional feature: define HSV_SCHED_VAL_LIMIT_EN to clamp the latched
// brightness to MAX_VAL. Undefined (default), val passes through unchanged.
//
// Ports:
//   clk_100mhz, rst_n             clock, async active-low reset
//   frame_start                   one-cycle frame request
//   base_hue, hue_step, val       frame parameters, sampled on acceptance
//   busy, frame_done, err         frame status and sticky error flag
//   conv_hue, conv_val,
//   conv_valid_in                 request to the converter
//   conv_rgb, conv_valid_out      fixed-latency result from the converter
//   pix_rgb, pix_idx, pix_valid,
//   pix_ready                     indexed pixel stream to the LED driver
module hsv_frame_scheduler #(
    parameter int unsigned N_LEDS     = 60,
    parameter int unsigned IDX_W      = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  MAX_VAL    = 8'd200
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [8:0]       base_hue,
    input  logic [8:0]       hue_step,
    input  logic [7:0]       val,
    output logic             busy,
    output logic             frame_done,
    output logic             err,
    output logic [8:0]       conv_hue,
    output logic [7:0]       conv_val,
    output logic             conv_valid_in,
    input  logic [23:0]      conv_rgb,
    input  logic             conv_valid_out,
    output logic [23:0]      pix_rgb,
    output logic [IDX_W-1:0] pix_idx,
    output logic             pix_valid,
    input  logic             pix_ready
);

    localparam int unsigned CNT_W = $clog2(N_LEDS + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    // Fold a hue in 0..719 back into 0..359 with a single subtraction.
    function automatic logic [8:0] hue_mod(input logic [9:0] h);
        return (h >= 10'd360) ? 9'(h - 10'd360) : h[8:0];
    endfunction

    state_t           state;
    logic [8:0]       cur_hue;
    logic [8:0]       step_l;
    logic [7:0]       val_l;
    logic [CNT_W-1:0] issued;
    logic [FC_W-1:0]  in_flight;
    logic [FC_W-1:0]  fifo_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [23:0]      mem [FIFO_DEPTH];

    logic [8:0]       base_mod;
    logic [8:0]       step_mod;
    logic [7:0]       val_sel;
    logic [8:0]       issue_hue;
    logic [8:0]       issue_step;
    logic [7:0]       issue_val;
    logic [8:0]       next_hue;
    logic             accept;
    logic             credit_ok;
    logic             issue_fire;
    logic             ret_ok;
    logic             push;
    logic             pop;
    logic             last_pix;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [FC_W-1:0]  count_nxt;
    logic [23:0]      head_nxt;

`ifdef HSV_SCHED_VAL_LIMIT_EN
    assign val_sel = (val > MAX_VAL) ? MAX_VAL : val;
`else
    logic unused_max_val;
    assign unused_max_val = ^MAX_VAL;
    assign val_sel        = val;
`endif

    // Issue/credit decisions and next FIFO head.
    always_comb begin
        base_mod   = hue_mod({1'b0, base_hue});
        step_mod   = hue_mod({1'b0, hue_step});
        accept     = (state == IDLE) && frame_start;
        // Credits cover both results still in the converter and those queued.
        credit_ok  = ({1'b0, in_flight} + {1'b0, fifo_count}) < (FC_W + 1)'(FIFO_DEPTH);
        issue_fire = credit_ok && (accept || (state == ISSUE));
        // The first request goes out straight from the accepted inputs.
        issue_hue  = accept ? base_mod : cur_hue;
        issue_step = accept ? step_mod : step_l;
        issue_val  = accept ? val_sel  : val_l;
        next_hue   = hue_mod({1'b0, issue_hue} + {1'b0, issue_step});
        ret_ok     = conv_valid_out && (in_flight != '0);
        pop        = pix_valid && pix_ready;
        push       = ret_ok && (fifo_count != FC_W'(FIFO_DEPTH));
        last_pix   = pop && (state != IDLE) && (pix_idx == IDX_W'(N_LEDS - 1));
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        count_nxt  = fifo_count + FC_W'(push) - FC_W'(pop);
        // A write landing on the new head slot bypasses the memory.
        head_nxt   = (push && (wr_ptr == rd_ptr_nxt)) ? conv_rgb : mem[rd_ptr_nxt];
    end

    // Result storage; contents need no reset since pointers gate their use.
    always_ff @(posedge clk_100mhz) begin
        if (push) begin
            mem[wr_ptr] <= conv_rgb;
        end
    end

    // Frame FSM, credit counters, FIFO pointers and registered outputs.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            err           <= 1'b0;
            conv_hue      <= '0;
            conv_val      <= '0;
            conv_valid_in <= 1'b0;
            pix_rgb       <= '0;
            pix_idx       <= '0;
            pix_valid     <= 1'b0;
            cur_hue       <= '0;
            step_l        <= '0;
            val_l         <= '0;
            issued        <= '0;
            in_flight     <= '0;
            fifo_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
        end else begin
            frame_done    <= 1'b0;
            conv_valid_in <= issue_fire;
            if (issue_fire) begin
                conv_hue <= issue_hue;
                conv_val <= issue_val;
            end
            in_flight  <= in_flight + FC_W'(issue_fire) - FC_W'(ret_ok);
            fifo_count <= count_nxt;
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr + PTR_W'(push);
            pix_valid  <= (count_nxt != '0);
            pix_rgb    <= head_nxt;
            if (pop) begin
                pix_idx <= last_pix ? '0 : pix_idx + IDX_W'(1);
            end
            // Unexpected results while busy, or FIFO overflow, latch err.
            if ((conv_valid_out && (in_flight == '0) && busy) || (ret_ok && !push)) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        val_l   <= val_sel;
                        step_l  <= step_mod;
                        cur_hue <= issue_fire ? next_hue : base_mod;
                        issued  <= CNT_W'(issue_fire);
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_fire) begin
                        cur_hue <= next_hue;
                        issued  <= issued + CNT_W'(1);
                        if (issued == CNT_W'(N_LEDS - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_pix) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
